// File: rtl/method_arb_pkg.sv
// Shared widths, defaults and FSM state codes for the method-call arbiter.
package method_arb_pkg;
    localparam int DEF_N_REQ    = 4;
    localparam int DEF_ARG_W    = 32;
    localparam int DEF_RET_W    = 32;
    localparam int DEF_START_TO = 15;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ISSUE      = 3'd1;
    localparam state_t ST_WAIT_START = 3'd2;
    localparam state_t ST_WAIT_DONE  = 3'd3;
    localparam state_t ST_RESP       = 3'd4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping mod N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0]   j;
    logic [IDX_W-1:0] jn;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = '0;
        jn      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // ptr is always < N_REQ, so a single subtract handles the wrap
            j = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (j >= N_W) j = j - N_W;
            jn = j[IDX_W-1:0];
            if (!any_o && req_i[jn]) begin
                any_o       = 1'b1;
                idx_o       = jn;
                grant_o[jn] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/method_call_arbiter.sv
// Shares one method port among N_REQ clients: round-robin grant, one call at a time,
// start timeout, latched return handed back with a one-cycle done pulse.
module method_call_arbiter
    import method_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int ARG_W    = DEF_ARG_W,
    parameter int RET_W    = DEF_RET_W,
    parameter int START_TO = DEF_START_TO
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [N_REQ-1:0]       cli_req_i,
    input  logic [N_REQ*ARG_W-1:0] cli_x_i,
    input  logic [N_REQ*ARG_W-1:0] cli_y_i,
    output logic [N_REQ-1:0]   cli_busy_o,
    output logic [N_REQ-1:0]   cli_done_o,
    output logic [RET_W-1:0]   cli_return_o,
    output logic               cli_err_o,
    output logic               m_req_o,
    output logic [ARG_W-1:0]   m_x_o,
    output logic [ARG_W-1:0]   m_y_o,
    input  logic               m_busy_i,
    input  logic [RET_W-1:0]   m_return_i
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(START_TO + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TO);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, gidx_q, gidx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, busy_q, busy_d, done;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [ARG_W-1:0] mx_q, mx_d, my_q, my_d;
    logic [RET_W-1:0] ret_q, ret_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i  (cli_req_i),
        .ptr_i  (ptr_q),
        .grant_o(arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    assign done = (state_q == ST_RESP) ? gnt_q : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mx_d    = mx_q;
        my_d    = my_q;
        ret_d   = ret_q;
        unique case (state_q)
            ST_IDLE: if (arb_any) begin
                gidx_d  = arb_idx;
                gnt_d   = arb_gnt;
                mx_d    = cli_x_i[arb_idx*ARG_W +: ARG_W];
                my_d    = cli_y_i[arb_idx*ARG_W +: ARG_W];
                err_d   = 1'b0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (m_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: if (!m_busy_i) begin
                ret_d   = m_return_i;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A client that drops its request is only forgotten if it is not the one in service.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (cli_req_i[i])                               busy_d[i] = 1'b1;
            else if (!(state_q != ST_IDLE && gnt_q[i]))     busy_d[i] = 1'b0;
        end
        busy_d = busy_d & ~done;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
            ret_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            ret_q   <= ret_d;
            busy_q  <= busy_d;
        end
    end

    assign m_req_o      = (state_q == ST_ISSUE);
    assign m_x_o        = mx_q;
    assign m_y_o        = my_q;
    assign cli_done_o   = done;
    assign cli_err_o    = (state_q == ST_RESP) && err_q;
    assign cli_return_o = ret_q;
    assign cli_busy_o   = busy_q;
endmodule

// File: tb/tb_method_call_arbiter.sv
// Bench for method_call_arbiter: directed scenarios plus random client traffic,
// checked against a transaction-level round-robin model.
module tb_method_call_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int STO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   cli_req;
    logic [N*W-1:0] cli_x, cli_y;
    logic [N-1:0]   cli_busy_o, cli_done_o;
    logic [W-1:0]   cli_return_o, m_x_o, m_y_o, m_return;
    logic           cli_err_o, m_req_o, m_busy;

    method_call_arbiter #(.N_REQ(N), .ARG_W(W), .RET_W(W), .START_TO(STO)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .cli_req_i(cli_req), .cli_x_i(cli_x), .cli_y_i(cli_y),
        .cli_busy_o(cli_busy_o), .cli_done_o(cli_done_o), .cli_return_o(cli_return_o),
        .cli_err_o(cli_err_o), .m_req_o(m_req_o), .m_x_o(m_x_o), .m_y_o(m_y_o),
        .m_busy_i(m_busy), .m_return_i(m_return)
    );

    // method model: busy one cycle after m_req, held 3 cycles, returns x + y
    logic nobusy;
    int   bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; bcnt <= 0; m_return <= '0;
        end else if (m_req_o && !nobusy) begin
            m_busy <= 1'b1; bcnt <= 3; m_return <= m_x_o + m_y_o;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) m_busy <= 1'b0;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [N-1:0] req_last, done_prev;
    int           ptr_m, cur, cyc, mreq_cyc, done_cyc, mreq_cnt;
    int           done_cnt [N];
    logic         outst, cur_err, last_err;
    logic [W-1:0] cur_x, cur_y, ret_m;
    int           served[$];
    logic [W-1:0] rets[$];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic sb_step();
        int r;
        if (!rst_n) begin
            ptr_m = 0; outst = 1'b0; ret_m = '0; done_prev = '0;
            return;
        end
        if (m_req_o) begin
            chk("overlap", 64'(outst), 64'(0));
            r = pick(req_last, ptr_m);
            chk("grant_has_req", 64'(r >= 0), 64'(1));
            if (r >= 0) begin
                cur = r;
                cur_x = cli_x[r*W +: W];
                cur_y = cli_y[r*W +: W];
                chk("m_x", 64'(m_x_o), 64'(cur_x));
                chk("m_y", 64'(m_y_o), 64'(cur_y));
            end
            outst = 1'b1; cur_err = nobusy; mreq_cyc = cyc; mreq_cnt++;
        end
        if (cli_done_o != '0) begin
            chk("done_outst", 64'(outst), 64'(1));
            chk("done_who", 64'(cli_done_o), 64'(1) << cur);
            chk("done_err", 64'(cli_err_o), 64'(cur_err));
            if (!cur_err) ret_m = cur_x + cur_y;
            chk("done_ret", 64'(cli_return_o), 64'(ret_m));
            served.push_back(cur);
            rets.push_back(cli_return_o);
            last_err = cli_err_o;
            done_cnt[cur]++;
            done_cyc = cyc;
            ptr_m = (cur + 1) % N;
            outst = 1'b0;
        end else begin
            chk("err_idle", 64'(cli_err_o), 64'(0));
        end
        chk("busy", 64'(cli_busy_o), 64'(req_last & ~done_prev));
        done_prev = cli_done_o;
    endtask

    // one clock: check at negedge, record at posedge, clients drop req after their done
    task automatic tick();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        req_last = cli_req;
        cyc++;
        #1;
        cli_req = cli_req & ~done_prev;
    endtask

    task automatic set_arg(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        cli_x[i*W +: W] = x;
        cli_y[i*W +: W] = y;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while ((cli_req != '0 || outst) && n < lim) begin tick(); n++; end
        chk(tag, 64'(n < lim), 64'(1));
        repeat (2) tick();
    endtask

    task automatic do_reset();
        cli_req = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_ctl", 64'({m_req_o, cli_err_o, cli_done_o, cli_busy_o}), 64'(0));
        chk("rst_args", 64'({m_x_o, m_y_o}), 64'(0));
        chk("rst_ret", 64'(cli_return_o), 64'(0));
        rst_n = 1'b1;
        served.delete();
        rets.delete();
    endtask

    initial begin
        int b_m, b_d, n;
        rst_n = 1'b0; cli_req = '0; cli_x = '0; cli_y = '0; nobusy = 1'b0;
        req_last = '0; done_prev = '0; cyc = 0; mreq_cnt = 0; outst = 1'b0;
        ptr_m = 0; cur = 0; cur_err = 1'b0; last_err = 1'b0; ret_m = '0;
        cur_x = '0; cur_y = '0; mreq_cyc = 0; done_cyc = 0;
        foreach (done_cnt[i]) done_cnt[i] = 0;
        tick();
        do_reset();

        // 1: single call
        b_m = mreq_cnt; b_d = done_cnt[0];
        set_arg(0, 3, 4); cli_req[0] = 1'b1;
        wait_idle("t1_timeout", 100);
        chk("t1_mreq", 64'(mreq_cnt - b_m), 64'(1));
        chk("t1_done", 64'(done_cnt[0] - b_d), 64'(1));
        chk("t1_ret", 64'(cli_return_o), 64'(7));

        // 2: all four together from pointer 0
        do_reset();
        b_m = mreq_cnt;
        for (int i = 0; i < N; i++) set_arg(i, W'(i), 10);
        cli_req = '1;
        wait_idle("t2_timeout", 200);
        chk("t2_mreq", 64'(mreq_cnt - b_m), 64'(4));
        chk("t2_count", 64'(served.size()), 64'(4));
        for (int i = 0; i < N && i < served.size(); i++) begin
            chk("t2_order", 64'(served[i]), 64'(i));
            chk("t2_ret", 64'(rets[i]), 64'(10 + i));
        end

        // 3: client 1 re-requests right after its done while 2,3 wait
        do_reset();
        for (int i = 1; i < N; i++) set_arg(i, W'(i), 1);
        cli_req = 4'b1110;
        b_d = done_cnt[1]; n = 0;
        while (done_cnt[1] == b_d && n < 50) begin tick(); n++; end
        chk("t3_first_timeout", 64'(n < 50), 64'(1));
        set_arg(1, 100, 1); cli_req[1] = 1'b1;
        wait_idle("t3_timeout", 200);
        chk("t3_count", 64'(served.size()), 64'(4));
        if (served.size() == 4) begin
            chk("t3_o0", 64'(served[0]), 64'(1));
            chk("t3_o1", 64'(served[1]), 64'(2));
            chk("t3_o2", 64'(served[2]), 64'(3));
            chk("t3_o3", 64'(served[3]), 64'(1));
        end

        // 4: method never goes busy -> start timeout
        nobusy = 1'b1;
        set_arg(3, 1, 2); cli_req[3] = 1'b1;
        wait_idle("t4_timeout", 100);
        chk("t4_err", 64'(last_err), 64'(1));
        chk("t4_lat", 64'(done_cyc - mreq_cyc), 64'(STO + 2));
        chk("t4_ret_kept", 64'(cli_return_o), 64'(101));
        nobusy = 1'b0;
        set_arg(0, 20, 22); cli_req[0] = 1'b1;
        wait_idle("t4b_timeout", 100);
        chk("t4_next_err", 64'(last_err), 64'(0));
        chk("t4_next_ret", 64'(cli_return_o), 64'(42));

        // 5: async reset during WAIT_DONE
        set_arg(0, 5, 6); cli_req[0] = 1'b1;
        n = 0;
        while (!m_busy && n < 20) begin tick(); n++; end
        chk("t5_busy_timeout", 64'(n < 20), 64'(1));
        tick();
        b_d = done_cnt[0]; b_m = mreq_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_ctl", 64'({m_req_o, cli_err_o, cli_done_o, cli_busy_o}), 64'(0));
        chk("t5_async_args", 64'({m_x_o, m_y_o}), 64'(0));
        chk("t5_async_ret", 64'(cli_return_o), 64'(0));
        cli_req = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t5_no_done", 64'(done_cnt[0] - b_d), 64'(0));
        chk("t5_no_mreq", 64'(mreq_cnt - b_m), 64'(0));
        set_arg(1, 7, 8); cli_req[1] = 1'b1;
        wait_idle("t5b_timeout", 100);
        chk("t5_after_ret", 64'(cli_return_o), 64'(15));

        // 6: client 2 withdraws while client 0 is in service
        b_m = mreq_cnt; b_d = done_cnt[2];
        set_arg(0, 1, 1); cli_req[0] = 1'b1;
        repeat (2) tick();
        set_arg(2, 9, 9); cli_req[2] = 1'b1;
        repeat (3) tick();
        chk("t6_busy_set", 64'(cli_busy_o[2]), 64'(1));
        cli_req[2] = 1'b0;
        repeat (2) tick();
        chk("t6_busy_clr", 64'(cli_busy_o[2]), 64'(0));
        wait_idle("t6_timeout", 100);
        chk("t6_mreq", 64'(mreq_cnt - b_m), 64'(1));
        chk("t6_no_done", 64'(done_cnt[2] - b_d), 64'(0));

        // random traffic
        do_reset();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!cli_req[i] && $urandom_range(0, 3) == 0) begin
                    set_arg(i, W'($urandom), W'($urandom));
                    cli_req[i] = 1'b1;
                end
            end
            tick();
        end
        wait_idle("rand_drain", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
